timer_sched: RTL and testbench
==============================

TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Port clk  input  1  rising-edge clock for all state.
REQ-002 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-003 Port req  input  4  per-requester timer request, level, held until matching cmpl bit.
REQ-004 Port req_delay  input  16  four packed 4-bit delay codes, requester i at bits [4i+3:4i].
REQ-005 Port gnt  output  4  one-hot grant, high from grant cycle through the cmpl cycle.
REQ-006 Port cmpl  output  4  one-cycle completion pulse to the granted requester.
REQ-007 Port err  output  4  one-cycle watchdog-abort pulse to the granted requester.
REQ-008 Port busy  output  1  high whenever state is not IDLE.
REQ-009 Port tmr_data  output  1  serial start-pattern/delay stream to the shared timer.
REQ-010 Port tmr_ack  output  1  acknowledge to the shared timer.
REQ-011 Port tmr_abort  output  1  one-cycle abort pulse to the shared timer.
REQ-012 Port tmr_done  input  1  timer finished, level, held until acknowledged.

Function
REQ-013 States SHALL be IDLE, PAT, DLY, RUN, ACK; encoding fixed in package.
REQ-014 IDLE: tmr_data=0; if any req bit high, grant winner, latch its 4-bit delay, go PAT.
REQ-015 Arbitration SHALL be round-robin, search starting at last_granted+1 mod 4; last_granted resets to 3.
REQ-016 PAT: 4 cycles driving tmr_data = 1,1,0,1 in order, then DLY.
REQ-017 DLY: 4 cycles driving latched delay MSB first (d3,d2,d1,d0), then RUN; stream gap-free, 8 bits total.
REQ-018 RUN: tmr_data=0; on tmr_done=1 go ACK.
REQ-019 ACK: exactly one cycle, tmr_ack=1 and cmpl[granted]=1; next state IDLE, gnt cleared.
REQ-020 Minimum one IDLE cycle between completion and the next PAT first bit.
REQ-021 First pattern bit appears in the cycle after the grant cycle.
REQ-022 req drop during PAT..RUN SHALL be ignored; operation completes, cmpl still pulsed.
REQ-023 req_delay changes after grant SHALL NOT affect the serialized delay.
REQ-024 tmr_done high in IDLE/PAT/DLY SHALL be ignored.
REQ-025 cmpl and err SHALL never both pulse for one grant; at most one bit of gnt/cmpl/err high.

Reset
REQ-026 reset_n low SHALL force state IDLE, last_granted=3, gnt/cmpl/err/tmr_data/tmr_ack/tmr_abort/busy all 0, delay register 0, immediately and independent of clk.
REQ-027 Reset mid-operation SHALL abandon the grant without cmpl or err pulse.

Configuration
REQ-028 Macro TIMER_SCHED_WDOG_EN defined: 15-bit counter cleared on RUN entry, incremented each RUN cycle; at 17000 without tmr_done, one cycle of tmr_abort=1 and err[granted]=1, then IDLE.
REQ-029 Macro undefined: no counter, tmr_abort and err tied 0, RUN waits indefinitely.

Structure
REQ-030 Package timer_sched_pkg SHALL hold state enum, NREQ=4, DLY_W=4, START_PATTERN=4'b1101, WDOG_LIMIT=17000.
REQ-031 Round-robin arbiter SHALL be a sub-module named timer_sched_rr_arb (req, last_granted in; one-hot grant out).

Verification
REQ-032 req=0001, delay0=4'h2 -> gnt=0001, tmr_data 1,1,0,1,0,0,1,0 from next cycle; tmr_done after 3000 cycles -> tmr_ack and cmpl=0001 same cycle.
REQ-033 req=1111 held continuously -> grants 0001,0010,0100,1000,0001 in order.
REQ-034 req1 dropped during DLY with delay 4'hF -> stream still ends 1,1,1,1; cmpl=0010 after tmr_done.
REQ-035 reset_n low during RUN -> all outputs 0 asynchronously; after release, req=0100 -> gnt=0100 (pointer reset).
REQ-036 With TIMER_SCHED_WDOG_EN, tmr_done held 0 -> tmr_abort and err=granted bit exactly 17000 cycles after RUN entry, no cmpl.
REQ-037 tmr_done=1 asserted during PAT -> no ack until RUN; ack one cycle only.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer scheduler.
package timer_sched_pkg;

    localparam int unsigned NREQ       = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned DLY_W      = 4;
    localparam int unsigned PAT_W      = 4;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned WDOG_W     = 15;
    localparam int unsigned WDOG_LIMIT = 17000;

    localparam logic [PAT_W-1:0] START_PATTERN = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PAT  = 3'd1,
        ST_DLY  = 3'd2,
        ST_RUN  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/timer_sched_rr_arb.sv
// Round-robin arbiter: search begins one past the last granted requester.
module timer_sched_rr_arb
    import timer_sched_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_granted,
    output logic [NREQ-1:0]  grant
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IDX_W'(32'(last_granted) + i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Arbitrates four requesters onto one shared timer via a serial pattern/delay stream.
// Optional watchdog abort in RUN when TIMER_SCHED_WDOG_EN is defined.
module timer_sched
    import timer_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DLY_W-1:0]   req_delay,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         cmpl,
    output logic [NREQ-1:0]         err,
    output logic                    busy,
    output logic                    tmr_data,
    output logic                    tmr_ack,
    output logic                    tmr_abort,
    input  logic                    tmr_done
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DLY_W-1:0] dly, dly_n;
    logic [IDX_W-1:0] last_granted, last_n;
    logic [NREQ-1:0]  gnt_n, cmpl_n, arb_grant;
    logic             ack_n, busy_n, tmr_data_n;
`ifdef TIMER_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog, wdog_n;
    logic [NREQ-1:0]   err_n;
    logic              abort_n;
`endif

    timer_sched_rr_arb u_arb (
        .req          (req),
        .last_granted (last_granted),
        .grant        (arb_grant)
    );

    // Next state; outputs other than tmr_data are registered from the next state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dly_n   = dly;
        last_n  = last_granted;
        gnt_n   = gnt;
        cmpl_n  = '0;
        ack_n   = 1'b0;
`ifdef TIMER_SCHED_WDOG_EN
        wdog_n  = wdog;
        err_n   = '0;
        abort_n = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_n = ST_PAT;
                    cnt_n   = '0;
                    gnt_n   = arb_grant;
                    last_n  = onehot_to_idx(arb_grant);
                    dly_n   = req_delay[last_n*DLY_W +: DLY_W];
                end
            end
            ST_PAT: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PAT_W-1)) state_n = ST_DLY;
            end
            ST_DLY: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DLY_W-1)) begin
                    state_n = ST_RUN;
`ifdef TIMER_SCHED_WDOG_EN
                    wdog_n  = '0;
`endif
                end
            end
            ST_RUN: begin
                if (tmr_done) begin
                    state_n = ST_ACK;
                    ack_n   = 1'b1;
                    cmpl_n  = gnt;
                end
`ifdef TIMER_SCHED_WDOG_EN
                else if (wdog == WDOG_W'(WDOG_LIMIT-1)) begin
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                    err_n   = gnt;
                    abort_n = 1'b1;
                end else begin
                    wdog_n  = wdog + WDOG_W'(1);
                end
`endif
            end
            ST_ACK: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // Serial stream trails the state by one cycle so bit 0 follows the grant cycle.
    always_comb begin
        tmr_data_n = 1'b0;
        unique case (state)
            ST_PAT:  tmr_data_n = START_PATTERN[CNT_W'(PAT_W-1) - cnt];
            ST_DLY:  tmr_data_n = dly[CNT_W'(DLY_W-1) - cnt];
            default: tmr_data_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            dly          <= '0;
            last_granted <= IDX_W'(NREQ-1);
            gnt          <= '0;
            cmpl         <= '0;
            tmr_ack      <= 1'b0;
            busy         <= 1'b0;
            tmr_data     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            dly          <= dly_n;
            last_granted <= last_n;
            gnt          <= gnt_n;
            cmpl         <= cmpl_n;
            tmr_ack      <= ack_n;
            busy         <= busy_n;
            tmr_data     <= tmr_data_n;
        end
    end

`ifdef TIMER_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog      <= '0;
            err       <= '0;
            tmr_abort <= 1'b0;
        end else begin
            wdog      <= wdog_n;
            err       <= err_n;
            tmr_abort <= abort_n;
        end
    end
`else
    assign err       = '0;
    assign tmr_abort = 1'b0;
`endif

endmodule

// File: tb/tb_timer_sched.sv
// Randomized self-checking bench for timer_sched against a transaction-level model.
module tb_timer_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [15:0] req_delay = 16'h0;
    logic        tmr_done = 1'b0;
    logic [3:0]  gnt, cmpl, err;
    logic        busy, tmr_data, tmr_ack, tmr_abort;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int last_g = 3;

    always #5 clk = ~clk;

    timer_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_delay (req_delay),
        .gnt       (gnt),
        .cmpl      (cmpl),
        .err       (err),
        .busy      (busy),
        .tmr_data  (tmr_data),
        .tmr_ack   (tmr_ack),
        .tmr_abort (tmr_abort),
        .tmr_done  (tmr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_winner(input logic [3:0] mask);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (last_g + k) % 4;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Cycle-level invariants: one-hot vectors, ack tracks cmpl, busy tracks gnt.
    always @(negedge clk) begin
        if (reset_n) begin
            if ($countones(gnt) > 1 || $countones(cmpl) > 1 || $countones(err) > 1) viol++;
            if (cmpl != 4'b0 && err != 4'b0) viol++;
            if (tmr_ack != (cmpl != 4'b0)) viol++;
            if (busy != (gnt != 4'b0)) viol++;
`ifndef TIMER_SCHED_WDOG_EN
            if (err != 4'b0 || tmr_abort) viol++;
`endif
        end
    end

    task automatic run_txn(input logic [3:0] mask, input logic [15:0] dly, input int done_delay,
                           input bit drop_req, input bit early_done, input bit keep_req,
                           input bit rst_in_run);
        int w, n, spurious;
        logic [3:0] exp_d;
        logic [7:0] stream;
        w = rr_winner(mask);
        req = mask;
        req_delay = dly;
        exp_d = dly[4*w +: 4];
        stream = 8'h0;
        @(negedge clk);
        n = 1;
        while (gnt == 4'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("gnt", 32'(gnt), 32'(1 << w));
        check("gnt_lat", 32'(n), 32'(1));
        if (gnt == 4'b0) begin
            req = 4'b0;
            return;
        end
        last_g = w;
        if (early_done) tmr_done = 1'b1;
        req_delay = 16'($urandom);
        spurious = 0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            stream = {stream[6:0], tmr_data};
            if (tmr_ack || cmpl != 4'b0) spurious++;
            if (drop_req && b == 4) req = 4'b0;
        end
        check("stream", 32'(stream), 32'({4'b1101, exp_d}));
        if (rst_in_run) begin
            #2 reset_n = 1'b0;
            #1 check("rst_async", 32'({gnt, cmpl, err, busy, tmr_data, tmr_ack, tmr_abort}), 32'(0));
            req = 4'b0;
            tmr_done = 1'b0;
            @(negedge clk);
            check("rst_hold", 32'({gnt, cmpl, err, busy, tmr_data, tmr_ack, tmr_abort}), 32'(0));
            reset_n = 1'b1;
            last_g = 3;
            return;
        end
`ifdef TIMER_SCHED_WDOG_EN
        if (done_delay < 0) begin
            for (int k = 1; k <= 17000; k++) begin
                @(negedge clk);
                if (k < 17000 && (tmr_abort || err != 4'b0 || tmr_ack)) spurious++;
            end
            check("wd_early", 32'(spurious), 32'(0));
            check("wd_abort", 32'({tmr_abort, err, cmpl}), 32'({1'b1, 4'(1 << w), 4'b0}));
            req = 4'b0;
            @(negedge clk);
            check("wd_after", 32'({tmr_abort, err, gnt, busy}), 32'(0));
            return;
        end
`endif
        if (!early_done) begin
            repeat (done_delay) begin
                @(negedge clk);
                if (tmr_ack || cmpl != 4'b0) spurious++;
            end
            tmr_done = 1'b1;
        end
        check("no_early_ack", 32'(spurious), 32'(0));
        n = 0;
        while (!tmr_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_lat", 32'(n), 32'(1));
        check("cmpl", 32'(cmpl), 32'(1 << w));
        check("ack_gnt", 32'(gnt), 32'(1 << w));
        tmr_done = 1'b0;
        if (!keep_req) req = 4'b0;
        @(negedge clk);
        check("idle_gap", 32'({gnt, cmpl, busy, tmr_ack}), 32'(0));
    endtask

    initial begin
        #12;
        check("reset", 32'({gnt, cmpl, err, busy, tmr_data, tmr_ack, tmr_abort}), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Round-robin order with all requesters held high.
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 16'($urandom), 5, 1'b0, 1'b0, (i < 4), 1'b0);
        run_txn(4'b0001, 16'h0002, 3000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(4'b0010, 16'h00F0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(4'b1000, 16'($urandom), 0, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_txn(4'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 30),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

`ifdef TIMER_SCHED_WDOG_EN
        run_txn(4'b0100, 16'($urandom), -1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Reset mid-RUN, then the pointer must be back at 3.
        run_txn(4'b0001, 16'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_txn(4'b0101, 16'($urandom), 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(4'b0100, 16'($urandom), 2, 1'b0, 1'b0, 1'b0, 1'b0);

        check("invariants", 32'(viol), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
